// File: rtl/nf_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | nf_fetch_unit: single-outstanding instruction fetch stage with stall  |
// | hold buffer and branch redirect/kill handling.                        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module nf_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pc_src,
  input  logic [31:0] pc_branch,
  input  logic        stall_if,
  output logic [31:0] addr_i,
  output logic        req_i,
  input  logic        ack_i,
  input  logic [31:0] rd_i,
  output logic [31:0] instr_if,
  output logic [31:0] pc_if,
  output logic        valid_if,
  output logic        flush_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_KILL  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        hold_valid_q, hold_valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_pc;

  assign pc_plus4  = pc_q + 32'd4;
  assign branch_pc = {pc_branch[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_if_d      = pc_if_q;
    valid_d      = valid_q;
    flush_d      = 1'b0;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    hold_valid_d = hold_valid_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (ack_i) begin
          pc_d = pc_plus4;
          if (stall_if) begin
            hold_instr_d = rd_i;
            hold_pc_d    = pc_q;
            hold_valid_d = 1'b1;
            state_d      = S_HOLD;
          end else begin
            instr_d = rd_i;
            pc_if_d = pc_q;
            valid_d = 1'b1;
          end
        end else if (!stall_if) begin
          // Decode consumed the previous instruction and nothing new arrived.
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      S_HOLD: begin
        if (!stall_if) begin
          instr_d      = hold_instr_q;
          pc_if_d      = hold_pc_q;
          valid_d      = hold_valid_q;
          hold_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end
      S_KILL: begin
        if (ack_i) begin
          state_d = S_FETCH;
        end
        if (!stall_if) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect overrides stall and any instruction delivered this cycle.
    if (pc_src) begin
      pc_d         = branch_pc;
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
      flush_d      = 1'b1;
      hold_valid_d = 1'b0;
      if (state_q == S_FETCH) begin
        state_d = ack_i ? S_FETCH : S_KILL;
      end else if (state_q == S_HOLD) begin
        state_d = S_FETCH;
      end
    end

    // While killing, the stale request address must stay on the bus.
    addr_d = (state_d == S_KILL) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_if_q      <= RESET_PC;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= RESET_PC;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      pc_if_q      <= pc_if_d;
      valid_q      <= valid_d;
      flush_q      <= flush_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign addr_i   = addr_q;
  assign req_i    = (state_q == S_FETCH) || (state_q == S_KILL);
  assign instr_if = instr_q;
  assign pc_if    = pc_if_q;
  assign valid_if = valid_q;
  assign flush_id = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_nf_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for nf_fetch_unit: stimulus queues expected fetch
// addresses and delivered instructions; negedge monitors pop and compare.
module tb_nf_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pc_src;
  logic [31:0] pc_branch;
  logic        stall_if;
  logic [31:0] addr_i;
  logic        req_i;
  logic        ack_i;
  logic [31:0] rd_i;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic        valid_if;
  logic        flush_id;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  logic [31:0] exp_addr_q[$];
  item_t       exp_ins_q[$];
  item_t       mon_it;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  nf_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .pc_src   (pc_src),
    .pc_branch(pc_branch),
    .stall_if (stall_if),
    .addr_i   (addr_i),
    .req_i    (req_i),
    .ack_i    (ack_i),
    .rd_i     (rd_i),
    .instr_if (instr_if),
    .pc_if    (pc_if),
    .valid_if (valid_if),
    .flush_id (flush_id)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  assign rd_i = mem_word(addr_i);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a, input bit deliver);
    exp_addr_q.push_back(a);
    if (deliver) exp_ins_q.push_back({a, mem_word(a)});
  endtask

  // Monitors: a handshake consumes an expected address; a live, unstalled
  // instruction is taken by decode and consumes an expected instruction.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (req_i && ack_i) begin
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fetch_addr_unexpected actual=%h required=none", addr_i);
        end else begin
          chk("fetch_addr", addr_i, exp_addr_q.pop_front());
        end
      end
      if (valid_if && !stall_if) begin
        if (exp_ins_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL instr_unexpected actual=%h@%h required=none", instr_if, pc_if);
        end else begin
          mon_it = exp_ins_q.pop_front();
          chk("pc_if", pc_if, mon_it.pc);
          chk("instr_if", instr_if, mon_it.ins);
        end
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    ack_i     = 1'b0;
    stall_if  = 1'b0;
    pc_src    = 1'b0;
    pc_branch = 32'h0;
    repeat (2) cyc();
    chk("rst_addr", addr_i, 32'h0);
    chk("rst_req", {31'b0, req_i}, 32'h0);
    chk("rst_instr", instr_if, NOP);
    chk("rst_pc_if", pc_if, 32'h0);
    chk("rst_valid", {31'b0, valid_if}, 32'h0);
    chk("rst_flush", {31'b0, flush_id}, 32'h0);

    // Zero-wait streaming from reset release.
    resetn = 1'b1;
    ack_i  = 1'b1;
    chk("idle_req", {31'b0, req_i}, 32'h0);
    cyc();
    chk("first_req", {31'b0, req_i}, 32'h1);
    chk("first_valid", {31'b0, valid_if}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", addr_i, 32'(4 * i));
      push_fetch(32'(4 * i), 1'b1);
      cyc();
      if (i == 0) begin
        chk("seq_valid2", {31'b0, valid_if}, 32'h1);
        chk("seq_pc_if2", pc_if, 32'h0);
      end
    end
    ack_i = 1'b0;

    // Three wait states at 0x10.
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", addr_i, 32'h10);
      chk("wait_req", {31'b0, req_i}, 32'h1);
      cyc();
    end
    push_fetch(32'h10, 1'b1);
    ack_i = 1'b1;
    cyc();
    ack_i = 1'b0;
    chk("wait_pc_if", pc_if, 32'h10);
    chk("wait_instr", instr_if, mem_word(32'h10));

    // Ack under stall at 0x20 goes to the hold buffer.
    ack_i = 1'b1;
    push_fetch(32'h14, 1'b1);
    cyc();
    push_fetch(32'h18, 1'b1);
    cyc();
    push_fetch(32'h1C, 1'b1);
    cyc();
    chk("hold_pre_addr", addr_i, 32'h20);
    stall_if = 1'b1;
    push_fetch(32'h20, 1'b1);
    cyc();
    ack_i = 1'b0;
    chk("hold_req1", {31'b0, req_i}, 32'h0);
    chk("hold_pc_if1", pc_if, 32'h1C);
    cyc();
    chk("hold_req2", {31'b0, req_i}, 32'h0);
    chk("hold_pc_if2", pc_if, 32'h1C);
    chk("hold_valid2", {31'b0, valid_if}, 32'h1);
    stall_if = 1'b0;
    cyc();
    chk("hold_rel_pc_if", pc_if, 32'h20);
    chk("hold_rel_instr", instr_if, mem_word(32'h20));
    chk("hold_rel_addr", addr_i, 32'h24);
    chk("hold_rel_req", {31'b0, req_i}, 32'h1);

    // Redirect with a pending request: kill the late data.
    pc_src    = 1'b1;
    pc_branch = 32'h103;
    cyc();
    pc_src = 1'b0;
    chk("kill_flush", {31'b0, flush_id}, 32'h1);
    chk("kill_valid", {31'b0, valid_if}, 32'h0);
    chk("kill_instr", instr_if, NOP);
    chk("kill_req", {31'b0, req_i}, 32'h1);
    chk("kill_addr", addr_i, 32'h24);
    cyc();
    chk("kill_flush_once", {31'b0, flush_id}, 32'h0);
    chk("kill_addr_hold", addr_i, 32'h24);
    push_fetch(32'h24, 1'b0);
    ack_i = 1'b1;
    cyc();
    ack_i = 1'b0;
    chk("kill_new_addr", addr_i, 32'h100);
    chk("kill_new_valid", {31'b0, valid_if}, 32'h0);

    // Redirect, ack and stall together: redirect wins, no hold.
    push_fetch(32'h100, 1'b0);
    ack_i     = 1'b1;
    stall_if  = 1'b1;
    pc_src    = 1'b1;
    pc_branch = 32'h200;
    cyc();
    ack_i    = 1'b0;
    stall_if = 1'b0;
    pc_src   = 1'b0;
    chk("race_valid", {31'b0, valid_if}, 32'h0);
    chk("race_flush", {31'b0, flush_id}, 32'h1);
    chk("race_addr", addr_i, 32'h200);
    chk("race_req", {31'b0, req_i}, 32'h1);

    // Address wrap at the top of memory.
    push_fetch(32'h200, 1'b0);
    ack_i     = 1'b1;
    pc_src    = 1'b1;
    pc_branch = 32'hFFFF_FFFC;
    cyc();
    pc_src = 1'b0;
    chk("wrap_top_addr", addr_i, 32'hFFFF_FFFC);
    push_fetch(32'hFFFF_FFFC, 1'b1);
    cyc();
    chk("wrap_addr", addr_i, 32'h0);
    chk("wrap_flush_low", {31'b0, flush_id}, 32'h0);
    push_fetch(32'h0, 1'b1);
    cyc();
    push_fetch(32'h4, 1'b1);
    cyc();
    ack_i = 1'b0;
    chk("wrap_next_addr", addr_i, 32'h8);
    chk("wrap_pc_if", pc_if, 32'h4);

    // Reset asserted in the middle of KILL.
    pc_src    = 1'b1;
    pc_branch = 32'h300;
    cyc();
    pc_src = 1'b0;
    chk("k2_addr", addr_i, 32'h8);
    chk("k2_req", {31'b0, req_i}, 32'h1);
    chk("k2_flush", {31'b0, flush_id}, 32'h1);
    resetn = 1'b0;
    #1;
    chk("arst_addr", addr_i, 32'h0);
    chk("arst_req", {31'b0, req_i}, 32'h0);
    chk("arst_valid", {31'b0, valid_if}, 32'h0);
    chk("arst_instr", instr_if, NOP);
    chk("arst_pc_if", pc_if, 32'h0);
    chk("arst_flush", {31'b0, flush_id}, 32'h0);
    ack_i = 1'b1;
    cyc();
    cyc();
    ack_i  = 1'b0;
    resetn = 1'b1;
    chk("post_rst_req", {31'b0, req_i}, 32'h0);
    cyc();
    chk("post_rst_fetch_req", {31'b0, req_i}, 32'h1);
    chk("post_rst_addr", addr_i, 32'h0);
    chk("post_rst_valid", {31'b0, valid_if}, 32'h0);
    push_fetch(32'h0, 1'b1);
    ack_i = 1'b1;
    cyc();
    ack_i = 1'b0;
    chk("post_rst_next_addr", addr_i, 32'h4);
    cyc();
    cyc();

    chk("addr_queue_left", 32'(exp_addr_q.size()), 32'h0);
    chk("instr_queue_left", 32'(exp_ins_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
